// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
// Index widths are computed here so every file sizes its ports the same way.
package rr_arb_pkg;

  localparam int MAX_REQ = 32;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Lowest set bit wins, so an all-zero vector maps to index 0.
  function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int idx;
    idx = 0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      idx = oh[i] ? i : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward with wrap.
// The request vector is doubled so the rotation never aliases when N_REQ is not a power of 2.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [2*N_REQ-1:0] req2;
  logic [N_REQ-1:0]   rot;
  int                 pos;
  int                 sum;

  assign req2 = {req, req};
  assign rot  = req2[ptr +: N_REQ];

  // Priority scan of the rotated vector, then map the offset back to an absolute index.
  always_comb begin
    pos = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = rot[k] ? k : pos;
    end
    sum = int'(ptr) + pos;
    idx = (sum >= N_REQ) ? IDX_W'(sum - N_REQ) : IDX_W'(sum);
    any = |req;
    gnt = any ? (ONE << idx) : {N_REQ{1'b0}};
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// N-way round-robin arbiter that locks the grant for a whole burst, capped at MAX_BEATS,
// and rotates priority past the winner when the burst ends.
module rr_burst_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int MAX_BEATS = 8,
  localparam int IDX_W     = idx_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ-1:0] req_last,
  input  logic             res_ready,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             res_valid,
  output logic             res_last,
  output logic [N_REQ-1:0] req_ready
);

  localparam int               CNT_W    = idx_width(MAX_BEATS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE      = {{(N_REQ-1){1'b0}}, 1'b1};

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] beat_q, beat_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [IDX_W-1:0] win_idx;
  logic             owner_last;
  logic             cap_hit;
  logic             xfer;
  logic             eob;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Grant selection: locked bursts ignore the picker entirely.
  always_comb begin
    grant   = {N_REQ{1'b0}};
    win_idx = {IDX_W{1'b0}};
    case (state_q)
      ARB_LOCKED: begin
        win_idx = owner_q;
        grant   = ONE << owner_q;
      end
      ARB_OPEN: begin
        win_idx = pick_idx;
        grant   = pick_any ? pick_gnt : {N_REQ{1'b0}};
      end
      default: begin
        win_idx = {IDX_W{1'b0}};
        grant   = {N_REQ{1'b0}};
      end
    endcase
  end

  assign grant_idx  = IDX_W'(onehot_to_idx(MAX_REQ'(grant)));
  assign res_valid  = |(grant & req_valid);
  assign owner_last = |(grant & req_last & req_valid);
  assign cap_hit    = (int'(beat_q) + 1 == MAX_BEATS);
  assign res_last   = (|grant) & (owner_last | cap_hit);
  assign req_ready  = grant & {N_REQ{res_ready}};
  assign xfer       = res_valid & res_ready;
  assign eob        = xfer & res_last;

  // Burst bookkeeping; a burst that ends on its first beat never enters the locked state.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    if (eob) begin
      state_d = ARB_OPEN;
      beat_d  = {CNT_W{1'b0}};
      ptr_d   = (win_idx == LAST_IDX) ? {IDX_W{1'b0}} : win_idx + IDX_W'(1);
    end else if (xfer) begin
      state_d = ARB_LOCKED;
      owner_d = win_idx;
      beat_d  = beat_q + CNT_W'(1);
    end else begin
      state_d = state_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_OPEN;
      ptr_q   <= {IDX_W{1'b0}};
      owner_q <= {IDX_W{1'b0}};
      beat_q  <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
- N-way round-robin arbiter for one shared downstream resource with a single valid/ready port.
- Grants whole bursts: once a requester wins, the grant locks to it until its last beat transfers or a beat cap is reached.
- The pointer then rotates past the winner.
- Sits between the requester masters and the shared resource. It generalises the team's 2-request alternating arbiter to N requesters with burst locking and bounded hold time.

Parameters:
- N_REQ, 4, number of requesters (>= 2).
- MAX_BEATS, 8, maximum beats per grant before forced rotation (>= 1).
- IDX_W, $clog2(N_REQ), width of the index output (derived, not overridable).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  N_REQ  per-requester beat valid; bit i is requester i.
- req_last  input  N_REQ  per-requester last-beat flag; qualified by req_valid.
- res_ready  input  1  shared resource accepts a beat this cycle.
- grant  output  N_REQ  one-hot or zero; the current owner of the resource.
- grant_idx  output  IDX_W  binary index of the owner; 0 when grant is zero.
- res_valid  output  1  equals |(grant & req_valid).
- res_last  output  1  owner's req_last, OR forced high on the MAX_BEATS-th beat.
- req_ready  output  N_REQ  equals grant & {N_REQ{res_ready}}.

Behaviour:
- Registered state:
  - ptr (IDX_W): highest-priority requester for the next arbitration.
  - locked (1).
  - owner (IDX_W).
  - beat_cnt (counts beats 1..MAX_BEATS).
- Reset values: ptr=0, locked=0, owner=0, beat_cnt=0. After reset, grant=0, res_valid=0, req_ready=0 until an input request arrives.
- Outputs are combinational from state and inputs, with zero-cycle grant latency.
- Unlocked (arbitrate):
  - Winner is the first set bit of req_valid scanning ptr, ptr+1, ..., wrapping mod N_REQ.
  - grant is the one-hot of the winner; all zero if req_valid==0.
- Locked:
  - grant = onehot(owner), regardless of other requests.
  - If the owner drops req_valid mid-burst, the lock holds: grant stays on owner and res_valid=0.
  - No other requester is served during that time.
- Transfer = res_valid & res_ready.
- End of burst = transfer with (owner's req_last OR beat_cnt+1 == MAX_BEATS).
  - On end of burst: locked<=0, beat_cnt<=0, ptr<=(winner+1) mod N_REQ.
  - A single-beat burst (last on the first transfer) never sets locked.
- Transfer without end: locked<=1, owner<=winner, beat_cnt<=beat_cnt+1.
- No transfer: state unchanged.
  - While unlocked, grant may move between requesters from cycle to cycle.
  - ptr does not move without a completed burst.
- Simultaneous events:
  - A new request from a higher-priority requester while locked is ignored until the burst ends.
  - The next burst may start in the cycle immediately after end of burst (no bubble).
- Wrap-around: ptr wraps from N_REQ-1 to 0. The non-power-of-2 N_REQ case must handle the wrap without aliasing.
- Reset mid-burst takes effect on the next edge:
  - lock is dropped and ptr returns to 0.
  - Outputs follow the unlocked rule from that cycle onward.

Decomposition:
- Package rr_arb_pkg: function onehot_to_idx and a localparam-based helper for IDX_W computation.
- Sub-module rr_pick (combinational): inputs req[N_REQ] and ptr; outputs gnt one-hot, idx, any.
  - Implemented as a double-width rotate-and-priority scan.
  - Instantiated once in the unlocked path.

Test Plan (N_REQ=4, MAX_BEATS=4):
- Reset, then req_valid=0000, res_ready=1 -> grant=0000, res_valid=0, ptr stays 0.
- req_valid=1111, all req_last=1, res_ready=1 for 5 cycles -> grant 0001,0010,0100,1000,0001 (one beat each, rotation with wrap).
- Requester 1 sends a 3-beat burst (last on beat 3) while req_valid=1111 -> grant=0010 for 3 transfer cycles, then 0100.
- Requester 0 holds valid with req_last=0 for 6 beats, res_ready=1 -> res_last=1 on beat 4, grant moves to the next valid requester on cycle 5, ptr=1.
- Locked owner 2 deasserts req_valid for 2 cycles mid-burst while 0001 is pending -> grant stays 0100, res_valid=0, no transfer to requester 0.
- res_ready=0 for 3 cycles during a burst, then rst pulsed mid-burst -> beat_cnt frozen while stalled; after rst, locked=0, ptr=0, next grant goes to the lowest valid index.
